// File: rtl/seven_seg_mux.sv
// Two-digit time-multiplexed driver for a common-anode 7-segment pair.
// Blanks both anodes at every digit switch and commits staged values only at frame boundaries.
module seven_seg_mux #(
  parameter int REFRESH_DIV  = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] val0,
  input  logic [3:0] val1,
  input  logic       load,
  output logic       busy,
  output logic [3:0] s,
  output logic [1:0] anode,
  output logic       blank,
  output logic       digit_sel,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BLANK0 = 2'd0,
    ST_SHOW0  = 2'd1,
    ST_BLANK1 = 2'd2,
    ST_SHOW1  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_sh0;
  logic [3:0]    r_sh1;
  logic [3:0]    r_act0;
  logic [3:0]    r_act1;
  logic          r_pending;

  logic          w_in_blank;
  logic          w_last;
  logic          w_boundary;

  assign w_in_blank = (r_state == ST_BLANK0) || (r_state == ST_BLANK1);
  assign w_last     = (r_cnt == (w_in_blank ? BLANK_LAST : SHOW_LAST));
  assign w_boundary = w_last && (r_state == ST_SHOW1);
  assign busy       = r_pending;

  // Slot sequencer, shadow/active value staging and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_BLANK0;
      r_cnt      <= {CW{1'b0}};
      r_sh0      <= 4'h0;
      r_sh1      <= 4'h0;
      r_act0     <= 4'h0;
      r_act1     <= 4'h0;
      r_pending  <= 1'b0;
      s          <= 4'h0;
      anode      <= 2'b11;
      blank      <= 1'b1;
      digit_sel  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (w_last) begin
        r_cnt <= {CW{1'b0}};
        case (r_state)
          ST_BLANK0: begin
            r_state <= ST_SHOW0;
            anode   <= 2'b10;
            blank   <= 1'b0;
          end
          ST_SHOW0: begin
            r_state   <= ST_BLANK1;
            anode     <= 2'b11;
            blank     <= 1'b1;
            digit_sel <= 1'b1;
            s         <= r_act1;
          end
          ST_BLANK1: begin
            r_state <= ST_SHOW1;
            anode   <= 2'b01;
            blank   <= 1'b0;
          end
          ST_SHOW1: begin
            // Frame boundary: the decoder sees the committed digit-0 value while dark.
            r_state    <= ST_BLANK0;
            anode      <= 2'b11;
            blank      <= 1'b1;
            digit_sel  <= 1'b0;
            frame_tick <= 1'b1;
            s          <= r_pending ? r_sh0 : r_act0;
            if (r_pending) begin
              r_act0 <= r_sh0;
              r_act1 <= r_sh1;
            end else begin
              r_act0 <= r_act0;
              r_act1 <= r_act1;
            end
          end
          default: begin
            r_state   <= ST_BLANK0;
            anode     <= 2'b11;
            blank     <= 1'b1;
            digit_sel <= 1'b0;
          end
        endcase
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end

      // A load on the boundary edge re-arms pending so its values commit a frame later.
      if (load) begin
        r_sh0     <= val0;
        r_sh1     <= val1;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Two-digit time-multiplexing driver that sits directly upstream of the combinational 7-segment decoder. It alternates which 4-bit value is presented on the decoder input `s` and drives the two common-anode enables. A blanking interval at every digit switch prevents ghosting. New display values are staged and committed only at a frame boundary, so a digit pair never tears.

## Interface
- `REFRESH_DIV`, default 24000: clock cycles per digit slot. At 48 MHz this gives 2 kHz per slot and a 1 kHz frame rate.
- `BLANK_CYCLES`, default 480: cycles at the start of each slot during which both anodes are off.
- Legal range: 1 ≤ `BLANK_CYCLES`, and `BLANK_CYCLES` + 2 ≤ `REFRESH_DIV`. The counter width is $clog2(`REFRESH_DIV`).
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `val0` in 4: value for digit 0. Sampled only when `load`=1.
- `val1` in 4: value for digit 1. Sampled only when `load`=1.
- `load` in 1: one-cycle strobe that captures `val0`/`val1` into the shadow registers.
- `busy` out 1: high while a captured update waits for its frame boundary.
- `s` out 4: registered nibble to the decoder.
- `anode` out 2: registered anode enables, active-low. Bit n enables digit n.
- `blank` out 1: registered; high during blanking intervals.
- `digit_sel` out 1: registered; index of the digit currently owned.
- `frame_tick` out 1: registered one-cycle pulse at the frame boundary.

## Operation
- State machine, in a fixed cycle: BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK0.
  - BLANKn lasts `BLANK_CYCLES` cycles.
  - SHOWn lasts `REFRESH_DIV`−`BLANK_CYCLES` cycles.
- Slot counter `cnt`:
  - Counts 0 up to the state's length−1.
  - On the last count it clears to 0 and the state advances.
- Registers:
  - Shadow registers `sh0`/`sh1` and the `pending` flag.
  - Active registers `act0`/`act1`.
  - `busy` = `pending`.
- Load:
  - `load`=1 writes `sh0`/`sh1` ← `val0`/`val1` and sets `pending`=1.
  - Repeated loads before the boundary overwrite the shadow; the last load wins.
- Frame boundary (the SHOW1 → BLANK0 edge):
  - If `pending`=1: `act0`/`act1` ← `sh0`/`sh1`, and `pending` clears.
  - `frame_tick`=1 for exactly that cycle, whether or not an update was pending.
- `load` on the boundary edge:
  - The transfer uses the pre-edge shadow.
  - The shadow then takes the new values and `pending` stays 1, so the new values commit one frame later.
- Output `s`:
  - Changes only on the edge entering BLANKn. The decoder therefore settles while both anodes are off.
  - Entering BLANK0: `s` ← (`pending` ? `sh0` : `act0`).
  - Entering BLANK1: `s` ← `act1`.
- Outputs per state:
  - `anode`=2'b11 in BLANK states, 2'b10 in SHOW0, 2'b01 in SHOW1.
  - `blank`=1 exactly in BLANK states.
  - `digit_sel`=0 in BLANK0/SHOW0 and 1 in BLANK1/SHOW1.
- The block never drives both anodes low at once.

## Timing
- Reset (`reset_n`=0 at an edge) forces:
  - State BLANK0, `cnt`=0.
  - `anode`=2'b11, `blank`=1, `s`=4'h0, `digit_sel`=0, `frame_tick`=0, `busy`=0.
  - `act0`/`act1` = 0 and `sh0`/`sh1` = 0.
  - A `load` in the same cycle is ignored.
- Reset mid-operation discards any pending update and restarts at BLANK0, `cnt`=0.
- First cycle after reset release is BLANK0 with `cnt`=0.
- Slot period is `REFRESH_DIV` cycles; frame period is 2·`REFRESH_DIV` cycles.
- Load-to-display latency:
  - Values appear on `s` on the next frame-boundary edge: at most 2·`REFRESH_DIV` cycles after `load`.
  - They light the display `BLANK_CYCLES` cycles later.
- `busy` rises the cycle after `load` and falls on the boundary edge that commits the update.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2.
- **Reset values.** Hold `reset_n`=0 for 3 cycles → `anode`=11, `blank`=1, `s`=0, `busy`=0, `frame_tick`=0, `digit_sel`=0.
- **Steady state.** Release reset, no load → per 16-cycle frame:
  - `anode` = 11×2, 10×6, 11×2, 01×6.
  - `frame_tick` pulses once every 16 cycles.
  - `anode` is never 00.
- **Deferred load.** Pulse `load` with `val0`=3, `val1`=9 in cycle 4 of SHOW0 →
  - `busy`=1 until the boundary; `s` unchanged through SHOW1.
  - `s`=3 on entering BLANK0, `s`=9 on entering BLANK1, and `busy` falls at the boundary.
- **Last load wins.** Load (1,2), then load (5,6) in the same frame → the display shows 5/6; 1/2 never appears on `s`.
- **Load on the boundary cycle.** Load (7,8) in the last SHOW1 cycle while (3,9) is pending →
  - `s`=3 this frame and `busy` stays 1.
  - `s`=7 the next frame.
- **Reset mid-SHOW1 with an update pending.** → `anode`=11 and `s`=0 next cycle, `busy`=0, and the pending values are never displayed.
